ft_de_btb: RTL and testbench
============================

Name: ft_de_btb

Overview:
- Fetch-to-decode pipeline register feeding the decoder. Holds PC, instruction, x1/xn hints, predict-taken, rv16 flag and interrupt sideband.
- Generalises the single-entry branch target buffer into a parametrised N-entry, fully associative BTB:
  - round-robin replacement;
  - duplicate-PC update;
  - combinational lookup port for fetch;
  - explicit invalidate input.
- Sits between the fetch unit and the decode stage.

Parameters:
XLEN, 32, PC/instruction width
BTB_DEPTH, 4, number of BTB entries (power of two, >=1)
BTB_DLY, 10, cycles after reset before lookups may hit
CAUSE_W, 5, interrupt cause code width

Ports:
clk  in  1  clock
cpurst_n  in  1  synchronous active-low reset
de_stall, exe_stall, memacc_stall  in  1 each  stall sources
fet_flush, branch_predict_err, fence_stall  in  1 each  kill sources
fetch_pc  in  XLEN  fetched PC
rv32_instr_todec  in  XLEN  fetched instruction (expanded)
rv16_instr_todec  in  16  raw compressed instruction
fet_is_x1, fet_is_xn, predict_bxxtaken, fe2de_rv16, g_int  in  1 each  fetch sideband
causecode_int  in  CAUSE_W  interrupt cause
de2fe_branch  in  1  decode reports branch; arm BTB capture
de2ex_inst_valid  in  1  decode issues instruction
btb_inval  in  1  invalidate all BTB entries
lookup_pc  in  XLEN  BTB lookup address
fe2de_pc_ffout, fe2de_instr_ffout  out  XLEN  registered PC/instruction
fe2de_valid_ffout  out  1  registered slot holds a real instruction
fet_is_x1_ffout, fet_is_xn_ffout, fe2de_predict_bxxtaken_ffout, fe2de_rv16_ffout, fe2de_g_int_ffout  out  1 each  registered sideband
fe2de_causecode_int_ffout  out  CAUSE_W  registered cause
de2ex_inst_valid_real  out  1  de2ex_inst_valid & ~stall
btb_hit  out  1  lookup hit
btb_instr  out  XLEN  instruction stored for lookup_pc
btb_ready  out  1  delay counter expired

Behaviour:
- Definitions: stall = de_stall|exe_stall|memacc_stall; kill = fet_flush|branch_predict_err|fence_stall.
- Reset (cpurst_n=0 at clk edge): all outputs, registers, BTB valid bits, round-robin pointer, capture flag and delay counter go to 0.
- Pipe register, priority order:
  - reset;
  - kill&~stall: instr, valid and all sideband cleared to 0 (bubble), PC still loads fetch_pc;
  - ~stall: all fields load, valid<=1;
  - stall: hold.
  - Kill during stall is ignored.
- de2ex_inst_valid_real is combinational.
- Capture flag:
  - Set by de2fe_branch.
  - Fire = flag & de2ex_inst_valid_real; fire clears the flag.
  - de2fe_branch in the same cycle as fire leaves the flag set (re-arm wins).
- BTB write, on fire:
  - key = fe2de_pc_ffout;
  - data = fe2de_rv16_ffout ? {zeros,fe2de_rv16_instr_q} : fe2de_instr_ffout.
  - fe2de_rv16_instr_q is rv16_instr_todec registered under the same enable as the pipe (~stall), clear on reset/kill.
  - Key already valid in an entry: overwrite that entry, pointer unchanged.
  - Otherwise: write entry[ptr], set its valid, ptr<=ptr+1 modulo BTB_DEPTH (wraps).
- btb_inval:
  - Clears all valid bits and resets ptr to 0 next edge.
  - Beats a same-cycle write; that write is dropped but the capture flag still clears.
- Delay counter:
  - Increments from 0 after reset, saturates at BTB_DLY.
  - btb_ready = (count >= BTB_DLY), so BTB_DLY=0 makes ready 1 on the first cycle out of reset.
- Lookup (combinational, zero latency):
  - btb_hit = btb_ready & any(valid[i] & key[i]==lookup_pc).
  - btb_instr = matching entry data, else 0.
  - At most one match is guaranteed by dedupe; implementation may OR-reduce.
  - A write becomes visible on lookup the cycle after its edge (no bypass).

Decomposition:
- Package ft_de_pkg holds:
  - default constants XLEN_D=32, BTB_DEPTH_D=4, BTB_DLY_D=10, CAUSE_W_D=5;
  - a NOP/bubble instruction constant (0).
- One sub-module, btb_array: storage, match, replacement pointer, inval.
- Pipe register and capture flag stay in ft_de_btb.

Test Plan:
- Reset then 3 unstalled fetches, PC 0x100/0x104/0x108 → fe2de_pc_ffout follows one cycle later, valid=1; btb_ready rises exactly 10 cycles after reset release.
- Hold exe_stall=1 2 cycles with fet_flush=1 → outputs hold, no bubble. Then drop the stall with fet_flush still 1 → instr=0, valid=0, pc=new fetch_pc.
- de2fe_branch, then de2ex_inst_valid with PC 0x200, instr 0x00A00093 → after ready, lookup_pc=0x200 gives hit=1, instr=0x00A00093. Repeat with rv16 0x4505 → stored as 0x00004505.
- 5 captures to distinct PCs (depth 4) → first PC misses, last four hit. Recapture an existing PC with a new instr → data updated, no eviction.
- btb_inval with a coincident fire → all lookups miss next cycle. Fire with de2fe_branch in the same cycle → flag stays 1 and the next issue captures.
- Assert cpurst_n=0 mid-capture with entries valid → all entries invalid, ready=0, counter restarts.

Source files
------------

// File: rtl/ft_de_pkg.sv
// Shared constants for the fetch-to-decode register and its branch target buffer.
package ft_de_pkg;

  localparam int XLEN_D      = 32;
  localparam int BTB_DEPTH_D = 4;
  localparam int BTB_DLY_D   = 10;
  localparam int CAUSE_W_D   = 5;

  // Instruction word placed in the decode slot when a bubble is inserted.
  localparam logic [63:0] NOP_INSTR = '0;

endpackage

// File: rtl/btb_array.sv
// Fully associative branch target buffer: storage, match, round-robin
// replacement and bulk invalidate. Lookup is purely combinational.
module btb_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            cpurst_n,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_key,
  input  logic [XLEN-1:0] wr_data,
  input  logic            inval,
  input  logic            lookup_en,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output logic [XLEN-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0] valid_q;
  logic [XLEN-1:0]  key_q  [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;

  logic [DEPTH-1:0] wr_match;
  logic             wr_dup;
  logic [DEPTH-1:0] wr_sel;
  logic [DEPTH-1:0] rd_match;

  // Pick the write target: an entry already holding the key, else the pointer slot.
  always_comb begin
    wr_match = '0;
    wr_sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_match[i] = valid_q[i] && (key_q[i] == wr_key);
    end
    wr_dup = |wr_match;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = wr_dup ? wr_match[i] : (ptr_q == PTR_W'(i));
    end
  end

  // Valid bits and replacement pointer; invalidate beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (!cpurst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (inval) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (wr_en) begin
      valid_q <= valid_q | wr_sel;
      if (!wr_dup) begin
        ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      end
    end
  end

  // Key/data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en && !inval) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          key_q[i]  <= wr_key;
          data_q[i] <= wr_data;
        end
      end
    end
  end

  // Zero-latency lookup; dedupe guarantees at most one match, so OR-reduce.
  always_comb begin
    rd_match = '0;
    rd_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_match[i] = lookup_en && valid_q[i] && (key_q[i] == lookup_pc);
      if (rd_match[i]) begin
        rd_data = rd_data | data_q[i];
      end
    end
    hit = |rd_match;
  end

endmodule

// File: rtl/ft_de_btb.sv
// Fetch-to-decode pipeline register with branch-capture flag, lookup-ready
// delay counter and an N-entry branch target buffer.
module ft_de_btb
  import ft_de_pkg::*;
#(
  parameter int XLEN      = XLEN_D,
  parameter int BTB_DEPTH = BTB_DEPTH_D,
  parameter int BTB_DLY   = BTB_DLY_D,
  parameter int CAUSE_W   = CAUSE_W_D
) (
  input  logic               clk,
  input  logic               cpurst_n,
  input  logic               de_stall,
  input  logic               exe_stall,
  input  logic               memacc_stall,
  input  logic               fet_flush,
  input  logic               branch_predict_err,
  input  logic               fence_stall,
  input  logic [XLEN-1:0]    fetch_pc,
  input  logic [XLEN-1:0]    rv32_instr_todec,
  input  logic [15:0]        rv16_instr_todec,
  input  logic               fet_is_x1,
  input  logic               fet_is_xn,
  input  logic               predict_bxxtaken,
  input  logic               fe2de_rv16,
  input  logic               g_int,
  input  logic [CAUSE_W-1:0] causecode_int,
  input  logic               de2fe_branch,
  input  logic               de2ex_inst_valid,
  input  logic               btb_inval,
  input  logic [XLEN-1:0]    lookup_pc,
  output logic [XLEN-1:0]    fe2de_pc_ffout,
  output logic [XLEN-1:0]    fe2de_instr_ffout,
  output logic               fe2de_valid_ffout,
  output logic               fet_is_x1_ffout,
  output logic               fet_is_xn_ffout,
  output logic               fe2de_predict_bxxtaken_ffout,
  output logic               fe2de_rv16_ffout,
  output logic               fe2de_g_int_ffout,
  output logic [CAUSE_W-1:0] fe2de_causecode_int_ffout,
  output logic               de2ex_inst_valid_real,
  output logic               btb_hit,
  output logic [XLEN-1:0]    btb_instr,
  output logic               btb_ready
);

  localparam int CNT_W = (BTB_DLY > 0) ? $clog2(BTB_DLY + 1) : 1;
  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(BTB_DLY);

  logic               stall;
  logic               kill;
  logic               fire;
  logic [XLEN-1:0]    wr_data;

  logic [XLEN-1:0]    pc_p1;
  logic [XLEN-1:0]    instr_p1;
  logic               vld_p1;
  logic               x1_p1;
  logic               xn_p1;
  logic               taken_p1;
  logic               rv16_p1;
  logic               gint_p1;
  logic [CAUSE_W-1:0] cause_p1;
  logic [15:0]        rv16_instr_p1;
  logic               cap_p1;
  logic [CNT_W-1:0]   dly_cnt;

  assign stall = de_stall | exe_stall | memacc_stall;
  assign kill  = fet_flush | branch_predict_err | fence_stall;

  assign de2ex_inst_valid_real = de2ex_inst_valid & ~stall;
  assign fire                  = cap_p1 & de2ex_inst_valid_real;
  assign wr_data = rv16_p1 ? {{(XLEN-16){1'b0}}, rv16_instr_p1} : instr_p1;

  // Fetch -> decode stage boundary: load, bubble on kill, hold on stall.
  always_ff @(posedge clk) begin
    if (!cpurst_n) begin
      pc_p1         <= '0;
      instr_p1      <= '0;
      vld_p1        <= 1'b0;
      x1_p1         <= 1'b0;
      xn_p1         <= 1'b0;
      taken_p1      <= 1'b0;
      rv16_p1       <= 1'b0;
      gint_p1       <= 1'b0;
      cause_p1      <= '0;
      rv16_instr_p1 <= '0;
    end else if (!stall) begin
      pc_p1 <= fetch_pc;
      if (kill) begin
        instr_p1      <= NOP_INSTR[XLEN-1:0];
        vld_p1        <= 1'b0;
        x1_p1         <= 1'b0;
        xn_p1         <= 1'b0;
        taken_p1      <= 1'b0;
        rv16_p1       <= 1'b0;
        gint_p1       <= 1'b0;
        cause_p1      <= '0;
        rv16_instr_p1 <= '0;
      end else begin
        instr_p1      <= rv32_instr_todec;
        vld_p1        <= 1'b1;
        x1_p1         <= fet_is_x1;
        xn_p1         <= fet_is_xn;
        taken_p1      <= predict_bxxtaken;
        rv16_p1       <= fe2de_rv16;
        gint_p1       <= g_int;
        cause_p1      <= causecode_int;
        rv16_instr_p1 <= rv16_instr_todec;
      end
    end
  end

  // Capture flag: armed by a decoded branch, consumed when the next instruction issues.
  always_ff @(posedge clk) begin
    if (!cpurst_n) begin
      cap_p1 <= 1'b0;
    end else if (de2fe_branch) begin
      cap_p1 <= 1'b1;
    end else if (fire) begin
      cap_p1 <= 1'b0;
    end
  end

  // Post-reset delay before lookups are allowed to hit; saturates at BTB_DLY.
  always_ff @(posedge clk) begin
    if (!cpurst_n) begin
      dly_cnt <= '0;
    end else if (dly_cnt != DLY_C) begin
      dly_cnt <= dly_cnt + CNT_W'(1);
    end
  end

  assign btb_ready = (dly_cnt >= DLY_C);

  assign fe2de_pc_ffout               = pc_p1;
  assign fe2de_instr_ffout            = instr_p1;
  assign fe2de_valid_ffout            = vld_p1;
  assign fet_is_x1_ffout              = x1_p1;
  assign fet_is_xn_ffout              = xn_p1;
  assign fe2de_predict_bxxtaken_ffout = taken_p1;
  assign fe2de_rv16_ffout             = rv16_p1;
  assign fe2de_g_int_ffout            = gint_p1;
  assign fe2de_causecode_int_ffout    = cause_p1;

  btb_array #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .cpurst_n  (cpurst_n),
    .wr_en     (fire),
    .wr_key    (pc_p1),
    .wr_data   (wr_data),
    .inval     (btb_inval),
    .lookup_en (btb_ready),
    .lookup_pc (lookup_pc),
    .hit       (btb_hit),
    .rd_data   (btb_instr)
  );

endmodule

// File: tb/tb_ft_de_btb.sv
// Bench for ft_de_btb: vector table for the pipe register, directed BTB
// sequences, and randomized traffic against a behavioural model.
module tb_ft_de_btb;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int DLY   = 10;
  localparam int CW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            cpurst_n = 1'b0;
  logic            de_stall = 1'b0, exe_stall = 1'b0, memacc_stall = 1'b0;
  logic            fet_flush = 1'b0, branch_predict_err = 1'b0, fence_stall = 1'b0;
  logic [XLEN-1:0] fetch_pc = '0, rv32_instr_todec = '0, lookup_pc = '0;
  logic [15:0]     rv16_instr_todec = '0;
  logic            fet_is_x1 = 1'b0, fet_is_xn = 1'b0, predict_bxxtaken = 1'b0;
  logic            fe2de_rv16 = 1'b0, g_int = 1'b0;
  logic [CW-1:0]   causecode_int = '0;
  logic            de2fe_branch = 1'b0, de2ex_inst_valid = 1'b0, btb_inval = 1'b0;

  logic [XLEN-1:0] fe2de_pc_ffout, fe2de_instr_ffout, btb_instr;
  logic            fe2de_valid_ffout, fet_is_x1_ffout, fet_is_xn_ffout;
  logic            fe2de_predict_bxxtaken_ffout, fe2de_rv16_ffout, fe2de_g_int_ffout;
  logic [CW-1:0]   fe2de_causecode_int_ffout;
  logic            de2ex_inst_valid_real, btb_hit, btb_ready;

  ft_de_btb #(.XLEN(XLEN), .BTB_DEPTH(DEPTH), .BTB_DLY(DLY), .CAUSE_W(CW)) dut (
    .clk(clk), .cpurst_n(cpurst_n),
    .de_stall(de_stall), .exe_stall(exe_stall), .memacc_stall(memacc_stall),
    .fet_flush(fet_flush), .branch_predict_err(branch_predict_err), .fence_stall(fence_stall),
    .fetch_pc(fetch_pc), .rv32_instr_todec(rv32_instr_todec), .rv16_instr_todec(rv16_instr_todec),
    .fet_is_x1(fet_is_x1), .fet_is_xn(fet_is_xn), .predict_bxxtaken(predict_bxxtaken),
    .fe2de_rv16(fe2de_rv16), .g_int(g_int), .causecode_int(causecode_int),
    .de2fe_branch(de2fe_branch), .de2ex_inst_valid(de2ex_inst_valid), .btb_inval(btb_inval),
    .lookup_pc(lookup_pc),
    .fe2de_pc_ffout(fe2de_pc_ffout), .fe2de_instr_ffout(fe2de_instr_ffout),
    .fe2de_valid_ffout(fe2de_valid_ffout), .fet_is_x1_ffout(fet_is_x1_ffout),
    .fet_is_xn_ffout(fet_is_xn_ffout), .fe2de_predict_bxxtaken_ffout(fe2de_predict_bxxtaken_ffout),
    .fe2de_rv16_ffout(fe2de_rv16_ffout), .fe2de_g_int_ffout(fe2de_g_int_ffout),
    .fe2de_causecode_int_ffout(fe2de_causecode_int_ffout),
    .de2ex_inst_valid_real(de2ex_inst_valid_real), .btb_hit(btb_hit),
    .btb_instr(btb_instr), .btb_ready(btb_ready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_x1, m_xn, m_pt, m_rv16, m_gint, m_flag;
  logic [4:0]  m_cause;
  logic [15:0] m_r16;
  int          m_cnt, m_ptr;
  logic        e_v [DEPTH];
  logic [31:0] e_k [DEPTH];
  logic [31:0] e_d [DEPTH];

  task automatic model_step();
    logic        stall, kill, fire;
    logic [31:0] wd;
    int          idx;
    stall = de_stall | exe_stall | memacc_stall;
    kill  = fet_flush | branch_predict_err | fence_stall;
    fire  = m_flag && de2ex_inst_valid && !stall;
    wd    = m_rv16 ? {16'h0, m_r16} : m_instr;
    if (!cpurst_n) begin
      m_pc = 0; m_instr = 0; m_valid = 0; m_x1 = 0; m_xn = 0; m_pt = 0;
      m_rv16 = 0; m_gint = 0; m_cause = 0; m_r16 = 0; m_flag = 0;
      m_cnt = 0; m_ptr = 0;
      for (int i = 0; i < DEPTH; i++) e_v[i] = 0;
    end else begin
      if (btb_inval) begin
        for (int i = 0; i < DEPTH; i++) e_v[i] = 0;
        m_ptr = 0;
      end else if (fire) begin
        idx = -1;
        for (int i = 0; i < DEPTH; i++) if (e_v[i] && e_k[i] == m_pc) idx = i;
        if (idx >= 0) e_d[idx] = wd;
        else begin
          e_k[m_ptr] = m_pc; e_d[m_ptr] = wd; e_v[m_ptr] = 1;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
      if (de2fe_branch) m_flag = 1;
      else if (fire) m_flag = 0;
      if (m_cnt < DLY) m_cnt++;
      if (!stall) begin
        m_pc = fetch_pc;
        if (kill) begin
          m_instr = 0; m_valid = 0; m_x1 = 0; m_xn = 0; m_pt = 0;
          m_rv16 = 0; m_gint = 0; m_cause = 0; m_r16 = 0;
        end else begin
          m_instr = rv32_instr_todec; m_valid = 1; m_x1 = fet_is_x1; m_xn = fet_is_xn;
          m_pt = predict_bxxtaken; m_rv16 = fe2de_rv16; m_gint = g_int;
          m_cause = causecode_int; m_r16 = rv16_instr_todec;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic        h, st;
    logic [31:0] d;
    h = 0; d = 0;
    if (m_cnt >= DLY)
      for (int i = 0; i < DEPTH; i++)
        if (e_v[i] && e_k[i] == lookup_pc) begin h = 1; d = e_d[i]; end
    st = de_stall | exe_stall | memacc_stall;
    chk("m_pc", fe2de_pc_ffout, m_pc);
    chk("m_instr", fe2de_instr_ffout, m_instr);
    chk("m_valid", fe2de_valid_ffout, m_valid);
    chk("m_x1", fet_is_x1_ffout, m_x1);
    chk("m_xn", fet_is_xn_ffout, m_xn);
    chk("m_taken", fe2de_predict_bxxtaken_ffout, m_pt);
    chk("m_rv16", fe2de_rv16_ffout, m_rv16);
    chk("m_gint", fe2de_g_int_ffout, m_gint);
    chk("m_cause", fe2de_causecode_int_ffout, m_cause);
    chk("m_vreal", de2ex_inst_valid_real, de2ex_inst_valid & ~st);
    chk("m_ready", btb_ready, m_cnt >= DLY);
    chk("m_hit", btb_hit, h);
    chk("m_binstr", btb_instr, d);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Idle cycle with a lookup address; checks hit/data against fixed expectations.
  task automatic look(input string n, input logic [31:0] pc, input logic eh, input logic [31:0] ed);
    lookup_pc = pc;
    cycle();
    chk({n, "_hit"}, btb_hit, eh);
    chk({n, "_data"}, btb_instr, ed);
  endtask

  task automatic capture(input logic [31:0] pc, input logic [31:0] ins, input logic r16, input logic [15:0] raw);
    fetch_pc = pc; rv32_instr_todec = ins; fe2de_rv16 = r16; rv16_instr_todec = raw;
    de2fe_branch = 1; cycle();
    de2fe_branch = 0; fe2de_rv16 = 0; rv16_instr_todec = 0;
    fetch_pc = pc + 32'h1000; rv32_instr_todec = 0; de2ex_inst_valid = 1; cycle();
    de2ex_inst_valid = 0; cycle();
  endtask

  typedef struct {
    logic [2:0]  st;   // {de, exe, memacc}
    logic [2:0]  kl;   // {flush, bpe, fence}
    logic [31:0] pc, ins, epc, eins;
    logic        ev, erdy;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'b000, 3'b000, 32'h100, 32'h11, 32'h100, 32'h11, 1'b1, 1'b0};
    tbl[1]  = '{3'b000, 3'b000, 32'h104, 32'h22, 32'h104, 32'h22, 1'b1, 1'b0};
    tbl[2]  = '{3'b000, 3'b000, 32'h108, 32'h33, 32'h108, 32'h33, 1'b1, 1'b0};
    tbl[3]  = '{3'b010, 3'b100, 32'h10C, 32'h44, 32'h108, 32'h33, 1'b1, 1'b0};
    tbl[4]  = '{3'b010, 3'b100, 32'h10C, 32'h44, 32'h108, 32'h33, 1'b1, 1'b0};
    tbl[5]  = '{3'b000, 3'b100, 32'h110, 32'h55, 32'h110, 32'h00, 1'b0, 1'b0};
    tbl[6]  = '{3'b000, 3'b010, 32'h114, 32'h56, 32'h114, 32'h00, 1'b0, 1'b0};
    tbl[7]  = '{3'b100, 3'b000, 32'h118, 32'h57, 32'h114, 32'h00, 1'b0, 1'b0};
    tbl[8]  = '{3'b001, 3'b001, 32'h118, 32'h57, 32'h114, 32'h00, 1'b0, 1'b0};
    tbl[9]  = '{3'b000, 3'b001, 32'h11C, 32'h58, 32'h11C, 32'h00, 1'b0, 1'b1};
    tbl[10] = '{3'b000, 3'b000, 32'h120, 32'h66, 32'h120, 32'h66, 1'b1, 1'b1};

    // Reset
    cpurst_n = 0;
    cycle(); cycle();
    chk("rst_pc", fe2de_pc_ffout, 0);
    chk("rst_valid", fe2de_valid_ffout, 0);
    chk("rst_ready", btb_ready, 0);
    cpurst_n = 1;

    // Pipe register vectors; ready must rise on the 10th edge after release
    for (int i = 0; i < 11; i++) begin
      {de_stall, exe_stall, memacc_stall}         = tbl[i].st;
      {fet_flush, branch_predict_err, fence_stall} = tbl[i].kl;
      fetch_pc = tbl[i].pc; rv32_instr_todec = tbl[i].ins;
      cycle();
      chk($sformatf("vec%0d_pc", i), fe2de_pc_ffout, tbl[i].epc);
      chk($sformatf("vec%0d_instr", i), fe2de_instr_ffout, tbl[i].eins);
      chk($sformatf("vec%0d_valid", i), fe2de_valid_ffout, tbl[i].ev);
      chk($sformatf("vec%0d_ready", i), btb_ready, tbl[i].erdy);
    end
    {de_stall, exe_stall, memacc_stall} = 3'b000;
    {fet_flush, branch_predict_err, fence_stall} = 3'b000;

    // 32-bit and compressed capture
    capture(32'h200, 32'h00A00093, 1'b0, 16'h0);
    look("cap32", 32'h200, 1'b1, 32'h00A00093);
    capture(32'h300, 32'hDEADBEEF, 1'b1, 16'h4505);
    look("cap16", 32'h300, 1'b1, 32'h00004505);
    look("miss", 32'h204, 1'b0, 32'h0);

    // Plain invalidate
    btb_inval = 1; cycle(); btb_inval = 0;
    look("inv200", 32'h200, 1'b0, 32'h0);

    // Five distinct captures into four entries: oldest evicted
    for (int i = 0; i < 5; i++) capture(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 16'h0);
    look("evict400", 32'h400, 1'b0, 32'h0);
    for (int i = 1; i < 5; i++) look($sformatf("keep%0d", i), 32'h400 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i));
    // Duplicate key: data updated, nothing evicted
    capture(32'h408, 32'hBB, 1'b0, 16'h0);
    look("dup408", 32'h408, 1'b1, 32'hBB);
    look("dup404", 32'h404, 1'b1, 32'hA1);
    look("dup40C", 32'h40C, 1'b1, 32'hA3);
    look("dup410", 32'h410, 1'b1, 32'hA4);

    // Invalidate coincident with a fire: write dropped, flag still cleared
    fetch_pc = 32'h500; rv32_instr_todec = 32'h55; de2fe_branch = 1; cycle();
    de2fe_branch = 0; fetch_pc = 32'h504; rv32_instr_todec = 32'h56;
    de2ex_inst_valid = 1; btb_inval = 1; cycle();
    btb_inval = 0; de2ex_inst_valid = 0;
    look("invf500", 32'h500, 1'b0, 32'h0);
    look("invf404", 32'h404, 1'b0, 32'h0);
    fetch_pc = 32'h508; de2ex_inst_valid = 1; cycle(); de2ex_inst_valid = 0;
    look("noflag504", 32'h504, 1'b0, 32'h0);

    // Fire with a same-cycle branch keeps the flag armed
    fetch_pc = 32'h700; rv32_instr_todec = 32'h77; de2fe_branch = 1; cycle();
    fetch_pc = 32'h704; rv32_instr_todec = 32'h78; de2ex_inst_valid = 1; cycle();
    de2fe_branch = 0; fetch_pc = 32'h708; rv32_instr_todec = 32'h79; cycle();
    fetch_pc = 32'h70C; rv32_instr_todec = 32'h7A; cycle();
    de2ex_inst_valid = 0;
    look("rearm700", 32'h700, 1'b1, 32'h77);
    look("rearm704", 32'h704, 1'b1, 32'h78);
    look("rearm708", 32'h708, 1'b0, 32'h0);

    // Reset in the middle of a capture
    fetch_pc = 32'h900; rv32_instr_todec = 32'h99; de2fe_branch = 1; cycle();
    de2fe_branch = 0; de2ex_inst_valid = 1; cpurst_n = 0; lookup_pc = 32'h700; cycle();
    chk("mrst_ready", btb_ready, 0);
    chk("mrst_hit", btb_hit, 0);
    chk("mrst_valid", fe2de_valid_ffout, 0);
    chk("mrst_pc", fe2de_pc_ffout, 0);
    cpurst_n = 1; de2ex_inst_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      chk($sformatf("mrst_rdy%0d", k), btb_ready, k >= 10);
    end
    look("mrst700", 32'h700, 1'b0, 32'h0);
    look("mrst900", 32'h900, 1'b0, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      de_stall           = ($urandom_range(0, 4) == 0);
      exe_stall          = ($urandom_range(0, 5) == 0);
      memacc_stall       = ($urandom_range(0, 6) == 0);
      fet_flush          = ($urandom_range(0, 7) == 0);
      branch_predict_err = ($urandom_range(0, 9) == 0);
      fence_stall        = ($urandom_range(0, 11) == 0);
      fetch_pc           = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      rv32_instr_todec   = $urandom;
      rv16_instr_todec   = 16'($urandom);
      fet_is_x1          = 1'($urandom);
      fet_is_xn          = 1'($urandom);
      predict_bxxtaken   = 1'($urandom);
      fe2de_rv16         = 1'($urandom);
      g_int              = 1'($urandom);
      causecode_int      = 5'($urandom);
      de2fe_branch       = ($urandom_range(0, 2) == 0);
      de2ex_inst_valid   = 1'($urandom);
      btb_inval          = ($urandom_range(0, 39) == 0);
      cpurst_n           = ($urandom_range(0, 199) != 0);
      lookup_pc          = 32'h1000 + 32'(4 * $urandom_range(0, 8));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
